// File: rtl/counter_sched.sv
// Shared-counter scheduler: grants one requester at a time a run of len+1 counts.
// Define COUNTER_SCHED_RR_EN for round-robin arbitration (default: fixed priority, lowest index).
module counter_sched #(
   parameter int bitwidth = 6,
   parameter int num_req  = 4,
   localparam int ID_W    = $clog2(num_req)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [num_req-1:0]          req,
   input  logic [num_req*bitwidth-1:0] len,
   output logic [num_req-1:0]          grant,
   output logic                        busy,
   output logic                        count_en,
   output logic [bitwidth-1:0]         count_val,
   output logic                        done,
   output logic [ID_W-1:0]             done_id
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [num_req-1:0]  r_grant;
   logic [bitwidth-1:0] r_target;
   logic [bitwidth-1:0] r_count;
   logic [ID_W-1:0]     r_owner;
   logic [ID_W-1:0]     r_done_id;
   logic                w_found;
   logic [ID_W-1:0]     w_win_id;

`ifdef COUNTER_SCHED_RR_EN
   logic [ID_W-1:0]     r_ptr;
   int                  w_idx;

   // Walk downward so the candidate closest to the pointer is the last one written.
   always_comb begin
      w_found  = 1'b0;
      w_win_id = '0;
      w_idx    = 0;
      for (int k = num_req - 1; k >= 0; k--) begin
         w_idx = (int'(r_ptr) + k) % num_req;
         if (req[w_idx]) begin
            w_found  = 1'b1;
            w_win_id = ID_W'(w_idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ptr <= '0;
      end else if (r_state == S_IDLE && w_found) begin
         r_ptr <= (w_win_id == ID_W'(num_req - 1)) ? '0 : w_win_id + 1'b1;
      end
   end
`else
   always_comb begin
      w_found  = 1'b0;
      w_win_id = '0;
      for (int i = num_req - 1; i >= 0; i--) begin
         if (req[i]) begin
            w_found  = 1'b1;
            w_win_id = ID_W'(i);
         end
      end
   end
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_found) w_state_next = S_RUN;
         S_RUN:   if (r_count == r_target) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_target  <= '0;
         r_count   <= '0;
         r_owner   <= '0;
         r_done_id <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant  <= {{(num_req-1){1'b0}}, 1'b1} << w_win_id;
                  r_target <= len[w_win_id*bitwidth +: bitwidth];
                  r_count  <= '0;
                  r_owner  <= w_win_id;
               end
            end
            S_RUN: begin
               // Terminal compare happens before increment, so the counter never wraps.
               if (r_count == r_target) begin
                  r_done_id <= r_owner;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            S_DONE: begin
               r_grant <= '0;
            end
            default: begin
               r_grant <= '0;
            end
         endcase
      end
   end

   assign grant     = r_grant;
   assign busy      = (r_state != S_IDLE);
   assign count_en  = (r_state == S_RUN);
   assign count_val = r_count;
   assign done      = (r_state == S_DONE);
   assign done_id   = r_done_id;

endmodule
